// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential signed divider.
package div_pkg;

    localparam int DIV_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_e;

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = '1;

    // Magnitude in one extra bit so that |MIN| is representable.
    function automatic logic [DIV_WIDTH:0] abs_ext(input logic [DIV_WIDTH-1:0] v);
        logic [DIV_WIDTH:0] ext;
        ext = {v[DIV_WIDTH-1], v};
        return v[DIV_WIDTH-1] ? -ext : ext;
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift {rem,quo} left, trial-subtract the divisor magnitude.
module div_restore_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH:0]   dvsr,
    output logic [WIDTH:0]   rem_n,
    output logic [WIDTH-1:0] quo_n
);

    logic [WIDTH+1:0] rem_sh;
    logic [WIDTH-1:0] quo_sh;

    // NOTE: every output gets a value on every path through this block, so no latch is inferred.
    always_comb begin
        rem_sh = {rem, quo[WIDTH-1]};
        quo_sh = {quo[WIDTH-2:0], 1'b0};
        rem_n  = rem_sh[WIDTH:0];
        quo_n  = quo_sh;
        if (rem_sh >= {1'b0, dvsr}) begin
            rem_n = (WIDTH+1)'(rem_sh - {1'b0, dvsr});
            quo_n = quo_sh | WIDTH'(1);
        end
    end

endmodule

// File: rtl/signed_seq_divider_16bit.sv
// Sequential signed divider: one quotient bit per clock on magnitudes, sign fix-up at the end.
module signed_seq_divider_16bit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH:0]   dvsr_q, dvsr_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quo;

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem   (rem_q),
        .quo   (quo_q),
        .dvsr  (dvsr_q),
        .rem_n (step_rem),
        .quo_n (step_quo)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        sign_a_d    = sign_a_q;
        sign_b_d    = sign_b_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_a_d = dividend[WIDTH-1];
                    sign_b_d = divisor[WIDTH-1];
                    rem_d    = '0;
                    quo_d    = WIDTH'(abs_ext(dividend));
                    dvsr_d   = abs_ext(divisor);
                    cnt_d    = '0;
                    dbz_d    = 1'b0;
                    ovf_d    = 1'b0;
                    if (divisor == '0) begin
                        state_d     = DONE;
                        quotient_d  = DIV_ZERO_Q;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                    end else if (dividend == MIN_VAL && divisor == '1) begin
                        state_d     = DONE;
                        quotient_d  = MIN_VAL;
                        remainder_d = '0;
                        ovf_d       = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d     = DONE;
                    quotient_d  = (sign_a_q ^ sign_b_q) ? -step_quo : step_quo;
                    remainder_d = sign_a_q ? -step_rem[WIDTH-1:0] : step_rem[WIDTH-1:0];
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    // NOTE: working registers are always reloaded on accept, so they carry no reset.
    always_ff @(posedge clk) begin
        cnt_q    <= cnt_d;
        rem_q    <= rem_d;
        quo_q    <= quo_d;
        dvsr_q   <= dvsr_d;
        sign_a_q <= sign_a_d;
        sign_b_q <= sign_b_d;
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_signed_seq_divider_16bit.sv
// Scoreboard bench: driver pushes expected results, a negedge monitor pops and compares.
module tb_signed_seq_divider_16bit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    signed_seq_divider_16bit dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] a, b, q, r;
        logic        dbz, ovf;
        int          hold;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        int sa, sbv;
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        e.a = a; e.b = b; e.dbz = 1'b0; e.ovf = 1'b0; e.hold = 0; e.acc = 0;
        if (b == 16'h0000) begin
            e.q = 16'hFFFF; e.r = a; e.dbz = 1'b1;
        end else if (a == 16'h8000 && b == 16'hFFFF) begin
            e.q = 16'h8000; e.r = 16'h0000; e.ovf = 1'b1;
        end else begin
            e.q = 16'(sa / sbv);
            e.r = 16'(sa % sbv);
        end
        return e;
    endfunction

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [15:0] q,
                         input logic [15:0] r, input logic dbz, input logic ovf, input int hold);
        exp_t e;
        int   to;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        to = 0;
        while (!in_ready && to < 200) begin
            @(negedge clk);
            to++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e.a = a; e.b = b; e.q = q; e.r = r; e.dbz = dbz; e.ovf = ovf;
        e.hold = hold; e.acc = cyc;
        sb.push_back(e);
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
    endtask

    // Monitor: compares each result once, then checks stability while out_ready is held low.
    initial begin : monitor
        bit          checked = 1'b0;
        int          hold = 0;
        int          lat;
        int          inv;
        exp_t        e;
        logic [15:0] snap_q, snap_r;
        logic        snap_dbz, snap_ovf;
        forever begin
            @(negedge clk);
            if (rst) begin
                out_ready = 1'b0;
                checked   = 1'b0;
            end else if (out_valid) begin
                if (!checked) begin
                    checked = 1'b1;
                    if (sb.size() == 0) begin
                        check("unexpected_result", 32'(out_valid), 32'd0);
                        hold = 0;
                    end else begin
                        e = sb.pop_front();
                        hold = e.hold;
                        check($sformatf("q %0d/%0d", $signed(e.a), $signed(e.b)), 32'(quotient), 32'(e.q));
                        check($sformatf("r %0d/%0d", $signed(e.a), $signed(e.b)), 32'(remainder), 32'(e.r));
                        check($sformatf("dbz %0d/%0d", $signed(e.a), $signed(e.b)), 32'(div_by_zero), 32'(e.dbz));
                        check($sformatf("ovf %0d/%0d", $signed(e.a), $signed(e.b)), 32'(overflow), 32'(e.ovf));
                        lat = cyc - e.acc + 1;
                        check($sformatf("latency %0d/%0d", $signed(e.a), $signed(e.b)), 32'(lat),
                              (e.dbz || e.ovf) ? 32'd1 : 32'd17);
                        if (!e.dbz && !e.ovf) begin
                            inv = int'($signed(quotient)) * int'($signed(e.b)) + int'($signed(remainder));
                            check("invariant", 32'(inv), 32'(int'($signed(e.a))));
                        end
                    end
                    snap_q = quotient; snap_r = remainder;
                    snap_dbz = div_by_zero; snap_ovf = overflow;
                end else begin
                    check("hold_q", 32'(quotient), 32'(snap_q));
                    check("hold_r", 32'(remainder), 32'(snap_r));
                    check("hold_flags", 32'({div_by_zero, overflow}), 32'({snap_dbz, snap_ovf}));
                end
                check("in_ready_while_done", 32'(in_ready), 32'd0);
                if (hold == 0) begin
                    out_ready = 1'b1;
                end else begin
                    out_ready = 1'b0;
                    hold--;
                end
            end else begin
                if (checked) check("in_ready_after_done", 32'(in_ready), 32'd1);
                checked   = 1'b0;
                out_ready = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        exp_t e;
        int   to;
        logic [15:0] a, b;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_flags", 32'({div_by_zero, overflow}), 32'd0);

        issue(16'd100,             16'd7,              16'd14,              16'd2,              1'b0, 1'b0, 0);
        issue(-16'sd100,           16'd7,              -16'sd14,            -16'sd2,            1'b0, 1'b0, 0);
        issue(16'd100,             -16'sd7,            -16'sd14,            16'd2,              1'b0, 1'b0, 0);
        issue(-16'sd100,           -16'sd7,            16'd14,              -16'sd2,            1'b0, 1'b0, 0);
        issue(16'd1234,            16'd0,              16'hFFFF,            16'd1234,           1'b1, 1'b0, 0);
        issue(16'h8000,            16'hFFFF,           16'h8000,            16'd0,              1'b0, 1'b1, 0);
        issue(16'h8000,            16'd1,              16'h8000,            16'd0,              1'b0, 1'b0, 0);
        issue(16'h7FFF,            16'h8000,           16'd0,               16'h7FFF,           1'b0, 1'b0, 0);
        issue(16'h8000,            16'h8000,           16'd1,               16'd0,              1'b0, 1'b0, 0);
        issue(16'h8000,            16'd3,              -16'sd10922,         -16'sd2,            1'b0, 1'b0, 0);
        issue(16'd5,               16'h8000,           16'd0,               16'd5,              1'b0, 1'b0, 0);
        issue(16'd0,               16'd5,              16'd0,               16'd0,              1'b0, 1'b0, 0);
        issue(16'h7FFF,            16'd1,              16'h7FFF,            16'd0,              1'b0, 1'b0, 0);
        issue(16'hFFFF,            16'd0,              16'hFFFF,            16'hFFFF,           1'b1, 1'b0, 0);
        issue(16'd0,               16'd0,              16'hFFFF,            16'd0,              1'b1, 1'b0, 2);

        // Held result plus in_valid pulses during CALC that must not be captured.
        issue(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 1'b0, 5);
        repeat (3) begin
            @(negedge clk);
            dividend = 16'd9;
            divisor  = 16'd9;
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;

        // Reset in the middle of a calculation discards the pending result.
        issue(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0, 0);
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        check("midcalc_rst_in_ready", 32'(in_ready), 32'd1);
        check("midcalc_rst_out_valid", 32'(out_valid), 32'd0);
        issue(16'd7, 16'd2, 16'd3, 16'd1, 1'b0, 1'b0, 0);

        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            case ($urandom_range(0, 15))
                0: b = 16'd0;
                1: begin a = 16'h8000; b = 16'hFFFF; end
                2, 3: b = 16'($signed(5'($urandom_range(0, 31))) - 16);
                default: ;
            endcase
            e = model(a, b);
            issue(a, b, e.q, e.r, e.dbz, e.ovf, int'($urandom_range(0, 2)));
        end

        to = 0;
        while ((sb.size() != 0 || out_valid) && to < 500) begin
            @(negedge clk);
            to++;
        end
        check("drain_pending", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
